fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/synchronous_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: opcode constants, sequencer states and J-immediate decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fetch_pkg;

  typedef enum logic {
    RUN         = 1'b0,
    WAIT_BRANCH = 1'b1
  } fetch_state_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // J-type immediate, sign-extended to 32 bits (bit 0 is always zero).
  function automatic logic [31:0] j_imm(input logic [31:0] insn);
    j_imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/synchronous_fifo.sv
// Generic single-clock FIFO with registered pointers and a combinational head read.
// Latency: a pushed word is readable at the head the cycle after the push.
// Backpressure: none internally; a push on full is accepted only together with a pop.
module synchronous_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_vld_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: streams sequential fetches into a queue, stalls on branches until the branch unit redirects.
// Latency: a memory response is visible at the queue head the cycle after imem_resp_valid.
// Backpressure: requests withheld while in-flight plus queued would exceed the queue; responses never stall.
// Option: FETCH_JAL_REDIRECT_EN resolves jal targets locally instead of waiting for the branch unit.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 64,
  parameter int                       QUEUE_DEPTH   = 8,
  parameter int                       MAX_INFLIGHT  = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [2:0]               BU_RS_ID      = 3'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  output logic                     instruction_valid,
  input  logic                     instruction_poll,
  output logic [31:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] instruction_pc,
  input  logic                     CDB_valid,
  input  logic [ADDRESS_WIDTH-1:0] CDB_result,
  input  logic [2:0]               CDB_rs_id,
  output logic                     redirect_error
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = 32 + ADDRESS_WIDTH;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]         inflight_q, inflight_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic                     redirect_error_q, redirect_error_d;
  logic                     rst_dly_q;

  logic [CNT_W-1:0]   q_count;
  logic [ENTRY_W-1:0] head_dat;
  logic [6:0]         resp_op;
  logic               out_en, req_ok, fire, push, pop, bu_redirect, stall_op;

  // Outputs stay quiet during reset and the cycle right after it.
  assign out_en = !rst && !rst_dly_q;

  assign req_ok = (state_q == RUN)
               && (({1'b0, inflight_q} + {1'b0, q_count}) < SUM_W'(QUEUE_DEPTH))
               && (inflight_q < CNT_W'(MAX_INFLIGHT));

  assign imem_req_valid    = out_en && req_ok;
  assign imem_req_addr     = out_en ? fetch_pc_q : '0;
  assign fire              = imem_req_valid && imem_req_ready;
  assign instruction_valid = out_en && (q_count != '0);
  assign instruction       = out_en ? head_dat[ENTRY_W-1 -: 32] : '0;
  assign instruction_pc    = out_en ? head_dat[ADDRESS_WIDTH-1:0] : '0;
  assign pop               = instruction_valid && instruction_poll;
  assign redirect_error    = out_en && redirect_error_q;

  assign resp_op     = imem_resp_data[6:0];
  assign push        = imem_resp_valid && (drop_cnt_q == '0);
  assign bu_redirect = CDB_valid && (CDB_rs_id == BU_RS_ID);

`ifdef FETCH_JAL_REDIRECT_EN
  assign stall_op = (resp_op == OP_BRANCH) || (resp_op == OP_JALR);
`else
  assign stall_op = (resp_op == OP_BRANCH) || (resp_op == OP_JALR) || (resp_op == OP_JAL);
`endif

  // Next-state: request/response bookkeeping, then the branch-unit redirect.
  // A response that coincides with a redirect is judged on pre-redirect drop state.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    resp_pc_d        = resp_pc_q;
    drop_cnt_d       = drop_cnt_q;
    redirect_error_d = redirect_error_q;
    inflight_d       = inflight_q + CNT_W'(fire) - CNT_W'(imem_resp_valid);

    if (fire) fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);

    if (imem_resp_valid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end else begin
        resp_pc_d = resp_pc_q + ADDRESS_WIDTH'(4);
        // Everything still outstanding (including a request firing now) is wrong-path.
        if (stall_op) begin
          state_d    = WAIT_BRANCH;
          drop_cnt_d = inflight_d;
        end
`ifdef FETCH_JAL_REDIRECT_EN
        else if (resp_op == OP_JAL) begin
          drop_cnt_d = inflight_d;
          fetch_pc_d = resp_pc_q + ADDRESS_WIDTH'($signed(j_imm(imem_resp_data)));
          resp_pc_d  = fetch_pc_d;
        end
`endif
      end
    end

    if (bu_redirect) begin
      if (state_q == WAIT_BRANCH) begin
        fetch_pc_d = CDB_result;
        resp_pc_d  = CDB_result;
        state_d    = RUN;
      end else begin
        redirect_error_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides every simultaneous event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      fetch_pc_q       <= RESET_PC;
      resp_pc_q        <= RESET_PC;
      inflight_q       <= '0;
      drop_cnt_q       <= '0;
      redirect_error_q <= 1'b0;
      rst_dly_q        <= 1'b1;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      resp_pc_q        <= resp_pc_d;
      inflight_q       <= inflight_d;
      drop_cnt_q       <= drop_cnt_d;
      redirect_error_q <= redirect_error_d;
      rst_dly_q        <= 1'b0;
    end
  end

  synchronous_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_vld_i(push),
    .push_dat_i({imem_resp_data, resp_pc_q}),
    .pop_i     (pop),
    .head_dat_o(head_dat),
    .count_o   (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
// Latency: the model predicts outputs for every cycle and the bench compares each cycle.
// Backpressure: memory responses are modelled in order with random latency and no stalls.
module tb_fetch_unit;

`ifdef FETCH_JAL_REDIRECT_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instruction_valid, instruction_poll;
  logic [31:0] instruction;
  logic [63:0] instruction_pc;
  logic        CDB_valid;
  logic [63:0] CDB_result;
  logic [2:0]  CDB_rs_id;
  logic        redirect_error;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instruction_valid(instruction_valid), .instruction_poll(instruction_poll),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .CDB_valid(CDB_valid), .CDB_result(CDB_result), .CDB_rs_id(CDB_rs_id),
    .redirect_error(redirect_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Program image, indexed by word address bits [9:2].
  logic [31:0] prog [256];

  // In-order memory: outstanding addresses with the cycle each is due back.
  logic [63:0] mq_addr[$];
  longint      mq_due[$];
  longint      cyc = 0;
  longint      last_due = 0;
  int          lat_min = 1, lat_max = 1;

  // Behavioural model of the fetch unit.
  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;
  ent_t        m_q[$];
  logic [63:0] m_fetch_pc = 64'h0, m_resp_pc = 64'h0;
  bit          m_wait = 0, m_err = 0, m_rst_prev = 1;
  int          m_inflight = 0, m_drop = 0;

  function automatic logic [63:0] jimm64(input logic [31:0] w);
    return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  // One clock cycle: drive memory response, compare outputs, advance model and memory.
  task automatic tick();
    bit          r_v, hold, e_rv, e_iv, a_fire, fire, pop, oldwait;
    logic [31:0] r_d;
    logic [63:0] ha, a_addr, e_addr;
    logic [6:0]  op;
    longint      c, due;
    int          ninf;
    ent_t        e;
    r_v = 1'b0;
    r_d = 32'h0;
    if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      ha  = mq_addr.pop_front();
      due = mq_due.pop_front();
      r_v = 1'b1;
      r_d = prog[ha[9:2]];
    end
    imem_resp_valid = r_v;
    imem_resp_data  = r_d;
    #1;
    hold   = rst || m_rst_prev;
    e_rv   = !hold && !m_wait && (m_inflight + m_q.size() < 8) && (m_inflight < 4);
    e_addr = hold ? 64'h0 : m_fetch_pc;
    e_iv   = !hold && (m_q.size() != 0);
    chk("req_valid", imem_req_valid, e_rv);
    chk("req_addr", imem_req_addr, e_addr);
    chk("instr_valid", instruction_valid, e_iv);
    if (e_iv) begin
      chk("instr", instruction, m_q[0].ins);
      chk("instr_pc", instruction_pc, m_q[0].pc);
    end
    chk("redirect_error", redirect_error, !hold && m_err);
    a_fire = imem_req_valid && imem_req_ready;
    a_addr = imem_req_addr;
    @(posedge clk);
    c = cyc;
    cyc++;
    if (rst) begin
      mq_addr.delete(); mq_due.delete(); last_due = cyc;
      m_fetch_pc = 64'h0; m_resp_pc = 64'h0; m_wait = 0; m_err = 0;
      m_inflight = 0; m_drop = 0; m_q.delete(); m_rst_prev = 1;
    end else begin
      if (a_fire) begin
        due = c + longint'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(a_addr);
        mq_due.push_back(due);
      end
      fire    = e_rv && imem_req_ready;
      pop     = e_iv && instruction_poll;
      oldwait = m_wait;
      ninf    = m_inflight + int'(fire) - int'(r_v);
      if (fire) m_fetch_pc += 64'd4;
      if (pop) void'(m_q.pop_front());
      if (r_v) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.ins = r_d; e.pc = m_resp_pc;
          m_q.push_back(e);
          op = r_d[6:0];
          if (op == 7'h63 || op == 7'h67 || (!JAL_EN && op == 7'h6F)) begin
            m_wait = 1; m_drop = ninf; m_resp_pc += 64'd4;
          end else if (JAL_EN && op == 7'h6F) begin
            m_drop = ninf; m_fetch_pc = m_resp_pc + jimm64(r_d); m_resp_pc = m_fetch_pc;
          end else begin
            m_resp_pc += 64'd4;
          end
        end
      end
      m_inflight = ninf;
      if (CDB_valid && CDB_rs_id == 3'd0) begin
        if (oldwait) begin
          m_fetch_pc = CDB_result; m_resp_pc = CDB_result; m_wait = 0;
        end else m_err = 1;
      end
      m_rst_prev = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      #1;
      if (imem_req_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic fill_addi();
    for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;
  endtask

  initial begin
    bit          ok, seen50;
    logic [63:0] a;
    int          r;
    logic [31:0] w;
    rst = 1'b1; imem_req_ready = 1'b0; instruction_poll = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    CDB_valid = 1'b0; CDB_result = '0; CDB_rs_id = '0;
    fill_addi();
    @(negedge clk);

    // Reset, sequential fetch with 1-cycle memory, queue fills.
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instruction_valid, 0);
    chk("rst_redirect_error", redirect_error, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", imem_req_valid, 0);
    wait_req(10, ok);
    chk("first_req_seen", ok, 1);
    chk("first_req_addr", imem_req_addr, 64'h0);
    repeat (20) tick();
    #1;
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_fetch_pc", imem_req_addr, 64'h20);
    chk("full_head_pc", instruction_pc, 64'h0);
    chk("full_head_instr", instruction, 64'h13);

    // Polling from a full queue while responses keep arriving.
    instruction_poll = 1'b1;
    tick();
    chk("pc_after_pop", instruction_pc, 64'h4);
    repeat (30) tick();

    // Branch at 0x8 with 2-cycle memory: trailing responses dropped, wait for BU.
    prog[2] = 32'h00000063;
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 20 && !m_wait; i++) tick();
    chk("branch_wait_entered", m_wait, 1);
    chk("branch_drop_cnt", m_drop, 2);
    chk("branch_fetch_pc", imem_req_addr, 64'h14);
    repeat (6) tick();
    #1;
    chk("wait_no_req", imem_req_valid, 0);
    CDB_valid = 1'b1; CDB_rs_id = 3'd5; CDB_result = 64'h300;
    tick();
    #1;
    chk("non_bu_ignored", imem_req_valid, 0);
    CDB_rs_id = 3'd0; CDB_result = 64'h100;
    tick();
    CDB_valid = 1'b0;
    #1;
    chk("redirect_req_valid", imem_req_valid, 1);
    chk("redirect_req_addr", imem_req_addr, 64'h100);
    repeat (10) tick();

    // BU redirect while running: ignored, sticky error until reset.
    imem_req_ready = 1'b0;
    a = imem_req_addr;
    CDB_valid = 1'b1; CDB_rs_id = 3'd0; CDB_result = 64'h200;
    tick();
    CDB_valid = 1'b0;
    #1;
    chk("run_redirect_pc", imem_req_addr, a);
    chk("redirect_error_set", redirect_error, 1);
    imem_req_ready = 1'b1;
    repeat (5) tick();
    chk("redirect_error_sticky", redirect_error, 1);
    do_reset();
    #1;
    chk("redirect_error_cleared", redirect_error, 0);

    // jal +0x40 at 0x10.
    fill_addi();
    prog[4] = 32'h0400006F;
    lat_min = 1; lat_max = 1;
    do_reset();
    seen50 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (imem_req_valid && imem_req_addr == 64'h50) seen50 = 1'b1;
      tick();
    end
    #1;
    if (JAL_EN) begin
      chk("jal_target_req", seen50, 1);
      chk("jal_no_wait", imem_req_valid, 1);
    end else begin
      chk("jal_target_req", seen50, 0);
      chk("jal_wait", imem_req_valid, 0);
      CDB_valid = 1'b1; CDB_rs_id = 3'd0; CDB_result = 64'h50;
      tick();
      CDB_valid = 1'b0;
      #1;
      chk("jal_bu_redirect_addr", imem_req_addr, 64'h50);
    end
    repeat (5) tick();

    // Reset in the middle of WAIT_BRANCH with two requests outstanding.
    fill_addi();
    prog[0] = 32'h00000063;
    lat_min = 3; lat_max = 3;
    instruction_poll = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = m_wait && (m_inflight == 2);
    end
    chk("reached_wait_2_inflight", ok, 1);
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_instr_valid", instruction_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_hold_req_valid", imem_req_valid, 0);
    tick();
    #1;
    chk("midrst_restart_valid", imem_req_valid, 1);
    chk("midrst_restart_addr", imem_req_addr, 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(99, 0);
      w = $urandom;
      if (r < 80)      prog[i] = {w[31:7], 7'h13};
      else if (r < 88) prog[i] = {w[31:7], 7'h63};
      else if (r < 93) prog[i] = {w[31:7], 7'h67};
      else             prog[i] = {w[31:7], 7'h6F};
    end
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      imem_req_ready   = ($urandom_range(3, 0) != 0);
      instruction_poll = ($urandom_range(4, 0) < 3);
      r = $urandom_range(99, 0);
      CDB_valid = 1'b0; CDB_rs_id = 3'd0; CDB_result = '0;
      if (m_wait && r < 15) begin
        CDB_valid = 1'b1; CDB_result = {52'h0, 10'($urandom_range(1023, 0)), 2'b00};
      end else if (r < 18) begin
        CDB_valid = 1'b1; CDB_rs_id = 3'($urandom_range(7, 1)); CDB_result = 64'($urandom);
      end else if (r < 19) begin
        CDB_valid = 1'b1; CDB_result = 64'h40;
      end
      rst = ($urandom_range(399, 0) == 0);
      tick();
    end
    rst = 1'b0;
    CDB_valid = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
